// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings and SRAM slave FSM state shared by the slave and its bench
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_t;

  // Sizes wider than a word are never aligned, which makes them illegal too.
  function automatic logic is_aligned(input hsize_t size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: is_aligned = 1'b1;
      HSIZE_HALF: is_aligned = ~addr_lo[0];
      HSIZE_WORD: is_aligned = (addr_lo == 2'b00);
      default:    is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB bus signals seen by one slave, with master and slave views
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - word-organised SRAM array with byte-enabled write and asynchronous read
module ahb_sram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  // Contents deliberately have no reset: a bus reset must not wipe memory.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB slave fronting an on-chip SRAM with programmable wait states
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 12,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  ahb_sram_slave_if.slave bus
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam int         OFF_W   = AW + 2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              write_q, write_d;
  hsize_t            size_q, size_d;
  logic              legal_q, legal_d;

  logic [REGION_BITS-1:0] samp_off;
  hsize_t                 samp_size;
  htrans_t                samp_trans;
  logic                   sample;
  logic                   samp_legal;

  logic [3:0]  be;
  logic        mem_we;
  logic [31:0] mem_rdata;
  hresp_t      resp;
  logic        unused_bus;

  assign samp_off   = bus.haddr[REGION_BITS-1:0];
  assign samp_size  = hsize_t'(bus.hsize);
  assign samp_trans = htrans_t'(bus.htrans);
  assign sample     = bus.hsel && bus.hready &&
                      (samp_trans == HTRANS_NONSEQ || samp_trans == HTRANS_SEQ);
  assign samp_legal = is_aligned(samp_size, samp_off[1:0]) &&
                      (32'(samp_off[REGION_BITS-1:2]) < 32'(MEM_DEPTH));

  // Every beat carries its own address, so burst type and high address bits are not needed.
  assign unused_bus = ^{bus.haddr[ADDR_W-1:REGION_BITS], bus.hburst};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      offset_q <= '0;
      write_q  <= 1'b0;
      size_q   <= HSIZE_BYTE;
      legal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      write_q  <= write_d;
      size_q   <= size_d;
      legal_q  <= legal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    offset_d      = offset_q;
    write_d       = write_q;
    size_d        = size_q;
    legal_d       = legal_q;
    bus.hreadyout = 1'b1;
    resp          = HRESP_OKAY;
    bus.hrdata    = '0;

    case (state_q)
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        resp          = HRESP_ERROR;
        state_d       = ST_ERR2;
      end
      default: begin
        // IDLE plus the final data-phase cycles (DONE, ERR2) accept the next address phase.
        if (state_q == ST_ERR2) begin
          resp = HRESP_ERROR;
        end
        if (state_q == ST_DONE && !write_q) begin
          bus.hrdata = mem_rdata;
        end
        state_d = ST_IDLE;
        if (sample) begin
          offset_d = samp_off[OFF_W-1:0];
          write_d  = bus.hwrite;
          size_d   = samp_size;
          legal_d  = samp_legal;
          cnt_d    = WS_LOAD;
          if (!samp_legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    endcase
  end

  assign bus.hresp = resp;

  always_comb begin
    be = 4'b0000;
    case (size_q)
      HSIZE_BYTE: be = 4'b0001 << offset_q[1:0];
      HSIZE_HALF: be = offset_q[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
  end

  assign mem_we = (state_q == ST_DONE) && write_q && legal_q;

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (offset_q[OFF_W-1:2]),
    .wdata_i (bus.hwdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench for ahb_sram_slave at 1, 0 and 3 wait states
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          dut;

  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic        rdy_a   [3];
  logic [1:0]  resp_a  [3];
  logic [31:0] rdata_a [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] b_addr  [8];
  logic        b_write [8];
  logic [2:0]  b_size  [8];
  logic [31:0] b_wdata [8];
  logic        l_rdy   [32];
  logic [1:0]  l_resp  [32];
  logic [31:0] l_rd    [32];
  int          l_n;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    ahb_sram_slave_if bus ();
    assign bus.hsel   = hsel && (dut == g);
    assign bus.haddr  = haddr;
    assign bus.htrans = htrans;
    assign bus.hwrite = hwrite;
    assign bus.hsize  = hsize;
    assign bus.hburst = HBURST_INCR4;
    assign bus.hwdata = hwdata;
    assign bus.hready = rdy;
    assign rdy_a[g]   = bus.hreadyout;
    assign resp_a[g]  = bus.hresp;
    assign rdata_a[g] = bus.hrdata;
    ahb_sram_slave #(.WAIT_STATES(WS)) u_dut (
      .clk   (clk),
      .reset (rst_n[g]),
      .bus   (bus)
    );
  end

  assign rdy   = rdy_a[dut];
  assign resp  = resp_a[dut];
  assign rdata = rdata_a[dut];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_addr(input int i);
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = b_addr[i];
    hwrite = b_write[i];
    hsize  = b_size[i];
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
  endtask

  // Pipelined master: next address is presented during the current data phase.
  task automatic run(input int n);
    int   ai;
    int   di;
    logic r;
    logic done;
    ai   = 0;
    done = 1'b0;
    l_n  = 0;
    drive_addr(0);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      l_rdy[c]  = rdy;
      l_resp[c] = resp;
      l_rd[c]   = rdata;
      l_n       = c + 1;
      r         = rdy;
      @(posedge clk);
      #1;
      if (r) begin
        di = (ai < n) ? ai : -1;
        if (di >= 0) hwdata = b_wdata[di];
        if (ai < n) ai++;
        if (ai < n) drive_addr(ai);
        else drive_idle();
        if (di < 0) begin
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) drive_idle();
    check("burst_complete", 32'(done), 32'd1);
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd);
    b_addr[0]  = a;
    b_write[0] = w;
    b_size[0]  = sz;
    b_wdata[0] = wd;
    run(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 3'b000;
    hwdata = 32'h0;
    dut    = 0;
    drive_idle();

    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      dut = k;
      @(negedge clk);
      check("rst_hreadyout", 32'(rdy), 32'd1);
      check("rst_hresp", 32'(resp), 32'd0);
      check("rst_hrdata", rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 3'b111;

    // One wait state
    dut = 0;
    xfer(32'h010, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    check("wr_len", l_n, 3);
    check("wr_wait_rdy", 32'(l_rdy[1]), 32'd0);
    check("wr_wait_resp", 32'(l_resp[1]), 32'd0);
    check("wr_done_rdy", 32'(l_rdy[2]), 32'd1);
    check("wr_done_resp", 32'(l_resp[2]), 32'd0);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0);
    check("rd_wait_hrdata", l_rd[1], 32'h0);
    check("rd_word", l_rd[2], 32'hDEADBEEF);

    xfer(32'h011, 1'b1, HSIZE_BYTE, 32'h0000AA00);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0);
    check("rd_after_byte", l_rd[2], 32'hDEADAAEF);
    xfer(32'h012, 1'b1, HSIZE_HALF, 32'h12340000);
    xfer(32'h010, 1'b0, HSIZE_WORD, 32'h0);
    check("rd_after_half", l_rd[2], 32'h1234AAEF);
    xfer(32'h011, 1'b0, HSIZE_BYTE, 32'h0);
    check("rd_byte_full_word", l_rd[2], 32'h1234AAEF);

    xfer(32'h000, 1'b1, HSIZE_WORD, 32'h11223344);
    xfer(32'h400, 1'b1, HSIZE_WORD, 32'hCAFEF00D);
    check("oor_len", l_n, 3);
    check("oor_err1_rdy", 32'(l_rdy[1]), 32'd0);
    check("oor_err1_resp", 32'(l_resp[1]), 32'd1);
    check("oor_err2_rdy", 32'(l_rdy[2]), 32'd1);
    check("oor_err2_resp", 32'(l_resp[2]), 32'd1);
    xfer(32'h000, 1'b0, HSIZE_WORD, 32'h0);
    check("oor_no_alias", l_rd[2], 32'h11223344);

    b_addr[0] = 32'h013; b_write[0] = 1'b0; b_size[0] = HSIZE_HALF; b_wdata[0] = 32'h0;
    b_addr[1] = 32'h020; b_write[1] = 1'b0; b_size[1] = 3'b011;     b_wdata[1] = 32'h0;
    run(2);
    check("err_pair_len", l_n, 5);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("err_pair_rdy_%0d", c), 32'(l_rdy[c]), (c % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("err_pair_resp_%0d", c), 32'(l_resp[c]), 32'd1);
      check($sformatf("err_pair_hrdata_%0d", c), l_rd[c], 32'h0);
    end

    b_addr[0] = 32'h014; b_write[0] = 1'b1; b_size[0] = HSIZE_WORD; b_wdata[0] = 32'hA5A55A5A;
    b_addr[1] = 32'h014; b_write[1] = 1'b0; b_size[1] = HSIZE_WORD; b_wdata[1] = 32'h0;
    run(2);
    check("raw_len", l_n, 5);
    check("raw_read", l_rd[4], 32'hA5A55A5A);

    // Zero wait states
    dut = 1;
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 32'(4 * i); b_write[i] = 1'b1; b_size[i] = HSIZE_WORD; b_wdata[i] = 32'(i + 1);
    end
    run(4);
    check("fill_len", l_n, 5);
    for (int i = 0; i < 4; i++) b_write[i] = 1'b0;
    run(4);
    check("incr4_len", l_n, 5);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("incr4_rdy_%0d", c), 32'(l_rdy[c]), 32'd1);
      check($sformatf("incr4_data_%0d", c), l_rd[c], 32'(c));
    end

    hsel = 1'b1; htrans = HTRANS_IDLE; haddr = 32'h004; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_sel_rdy", 32'(rdy), 32'd1);
    check("idle_sel_resp", 32'(resp), 32'd0);
    check("idle_sel_hrdata", rdata, 32'h0);
    htrans = HTRANS_BUSY;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("busy_sel_rdy", 32'(rdy), 32'd1);
    check("busy_sel_hrdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    drive_idle();

    // Three wait states, reset mid data phase
    dut = 2;
    xfer(32'h030, 1'b1, HSIZE_WORD, 32'h55AA55AA);
    check("ws3_len", l_n, 5);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h030; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    drive_idle();
    hwdata = 32'h99999999;
    @(negedge clk);
    check("ws3_wait_rdy", 32'(rdy), 32'd0);
    #2;
    rst_n[2] = 1'b0;
    #1;
    check("async_rst_rdy", 32'(rdy), 32'd1);
    check("async_rst_resp", 32'(resp), 32'd0);
    check("async_rst_hrdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    xfer(32'h030, 1'b0, HSIZE_WORD, 32'h0);
    check("rst_dropped_write", l_rd[4], 32'h55AA55AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave with a word-organised on-chip SRAM behind it; it attaches to the shared AHB interface alongside the existing slaves.
- Consumes the address/control phase driven by the granted master and answers in the data phase.
- Supports:
  - Programmable wait-state insertion.
  - Byte/halfword/word accesses.
  - Two-cycle ERROR response for illegal accesses.
- Provides the bus fabric with a second memory target for master/arbiter traffic.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width. Only 32 is supported.
- REGION_BITS, 12, number of low HADDR bits forming the slave-local byte offset.
- MEM_DEPTH, 256, number of 32-bit words. Power of 2, and MEM_DEPTH*4 <= 2**REGION_BITS.
- WAIT_STATES, 1, wait cycles inserted per valid transfer (0..15).

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the address decoder.
- haddr  in  ADDR_W  transfer address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  000 = byte, 001 = half, 010 = word.
- hburst  in  3  burst type. Ignored; every beat carries its own address.
- hwdata  in  DATA_W  write data, valid during the data phase.
- hready  in  1  bus-level ready (previous transfer complete).
- hreadyout  out  1  this slave's ready.
- hresp  out  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11. Only OKAY and ERROR are driven.
- hrdata  out  DATA_W  read data.

Behaviour:
- Reset state (reset low):
  - hreadyout=1, hresp=OKAY, hrdata=0.
  - FSM enters IDLE.
  - Pending transfer discarded; no memory write occurs.
  - SRAM contents are not cleared.
- Address sample: on a rising clk with hsel & hready & htrans[1], latch the following:
  - haddr offset (haddr[REGION_BITS-1:0]).
  - hwrite.
  - hsize.
  - Legality flag.
- Non-selected or IDLE/BUSY transfer sampled: zero-wait OKAY. hreadyout stays 1 and there is no side effect.
- Illegal access, if any of the following:
  - hsize > 010.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Word index (offset >> 2) >= MEM_DEPTH.
- FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE → on legal sample: WAIT if WAIT_STATES>0, else DONE.
  - IDLE → on illegal sample: ERR1.
  - WAIT: hreadyout=0, hresp=OKAY. A counter loads WAIT_STATES-1 and decrements; at 0, go to DONE.
  - DONE: hreadyout=1, hresp=OKAY.
    - Write: commit the byte-enabled hwdata to memory at this clock edge.
    - Read: hrdata = memory word (combinational from the array) this cycle.
  - ERR1: hreadyout=0, hresp=ERROR, no memory access.
  - ERR2: hreadyout=1, hresp=ERROR.
  - DONE and ERR2 are the final data-phase cycles. A new address phase is sampled at that same edge, giving pipelined back-to-back transfers: next state is WAIT/DONE/ERR1 per the new sample, or IDLE if none.
- Byte lanes (little-endian):
  - byte at addr[1:0]=n uses lane n (bits 8n+7:8n).
  - half at addr[1]=h uses lanes 2h, 2h+1.
  - word uses all four lanes.
  - Unused lanes of hrdata read as the memory's stored bytes; the full word is always returned.
- hrdata = 0 in every cycle that is not DONE-for-a-read.
- Read after write to the same word in consecutive transfers returns the new data, because the write commits before the read's DONE.
- hsel deasserted mid data phase: the current transfer still completes; the slave obeys only its latched state.
- Reset asserted mid-WAIT: the outputs above take their reset values immediately (asynchronous), and the write is dropped.

Decomposition:
- ahb_pkg:
  - htrans_t, hresp_t, hsize_t, hburst_t enums.
  - HRESP_OKAY/HRESP_ERROR constants.
  - Slave FSM state enum.
- Sub-module ahb_sram_mem:
  - MEM_DEPTH x 32 register array.
  - 4-bit byte-enable write port.
  - Asynchronous read port.
- Byte-enable generation from hsize/addr[1:0] stays in the parent.

Test Plan:
- WAIT_STATES=1: NONSEQ word write 0x010 with 0xDEADBEEF → one cycle hreadyout=0, then 1, hresp=00. Word read 0x010 → hrdata=0xDEADBEEF in its DONE cycle.
- Byte write 0x011 with hwdata=0x0000AA00 → word read 0x010 = 0xDEADAAEF. Half write 0x012 with 0x12340000 → read = 0x1234AAEF.
- Out-of-range word write 0x400 (MEM_DEPTH=256) → hreadyout 0/1 with hresp=01 both cycles; a subsequent read of 0x000 is unaffected.
- Misaligned half read at 0x013, then hsize=011 at 0x020 → two consecutive two-cycle ERROR responses; hrdata=0.
- Back-to-back pipelined INCR4 read (0x000, 0x004, 0x008, 0x00C) after prefilling 1..4, WAIT_STATES=0 → four consecutive hreadyout=1 cycles returning 1, 2, 3, 4. An IDLE transfer with hsel=1 → zero-wait OKAY.
- Reset driven low during WAIT of a write to 0x030 (WAIT_STATES=3) → hreadyout=1, hresp=00, hrdata=0 immediately; a later read of 0x030 returns the old contents.
